// File: rtl/secuenciador_multiciclo.sv
// Multicycle control sequencer: drives PC, IR, register bank, ALU and data memory strobes.
// States: IDLE 0 | FETCH 1 | DECODE 2 | EXECUTE 3 | MEMORY 4 | WRITEBACK 5 | HALT 6
module secuenciador_multiciclo #(
   parameter int MEM_TIMEOUT = 15,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [5:0]       opCode,
   input  logic             alu_zero,
   input  logic             mem_ready,
   input  logic             run,
   input  logic             step,
   output logic             pc_we,
   output logic             pc_src,
   output logic             ir_we,
   output logic             reg_we,
   output logic             reg_dst,
   output logic             alu_src,
   output logic [2:0]       alu_op,
   output logic             mem_to_reg,
   output logic             mem_en_r,
   output logic             mem_en_w,
   output logic [2:0]       state,
   output logic             halted,
   output logic             illegal,
   output logic             mem_err,
   output logic [CNT_W-1:0] instr_count
);

   localparam int TMR_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
   localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(MEM_TIMEOUT - 1);

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_HALT = 6'b111111;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_FETCH   = 3'd1,
      S_DECODE  = 3'd2,
      S_EXECUTE = 3'd3,
      S_MEMORY  = 3'd4,
      S_WB      = 3'd5,
      S_HALT    = 3'd6
   } state_t;

   state_t           state_q, state_d;
   logic             step_pend_q, step_pend_d;
   logic             illegal_q, illegal_d;
   logic             mem_err_q, mem_err_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [TMR_W-1:0] tmr_q, tmr_d;
   logic             retire;
   logic             is_r, is_addi, is_lw, is_sw, is_beq, is_halt, is_legal;

   assign is_r     = (opCode == OP_R);
   assign is_addi  = (opCode == OP_ADDI);
   assign is_lw    = (opCode == OP_LW);
   assign is_sw    = (opCode == OP_SW);
   assign is_beq   = (opCode == OP_BEQ);
   assign is_halt  = (opCode == OP_HALT);
   assign is_legal = is_r | is_addi | is_lw | is_sw | is_beq;

   always_comb begin
      state_d     = state_q;
      step_pend_d = step_pend_q;
      illegal_d   = illegal_q;
      mem_err_d   = mem_err_q;
      cnt_d       = cnt_q;
      tmr_d       = tmr_q;
      retire      = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (step) step_pend_d = 1'b1;
            if (run || step) state_d = S_FETCH;
         end
         S_FETCH: state_d = S_DECODE;
         S_DECODE: begin
            if (is_halt) begin
               state_d = S_HALT;
            end else if (is_legal) begin
               state_d = S_EXECUTE;
            end else begin
               illegal_d = 1'b1;
               retire    = 1'b1;
            end
         end
         S_EXECUTE: begin
            if (is_r || is_addi) begin
               state_d = S_WB;
            end else if (is_lw || is_sw) begin
               state_d = S_MEMORY;
               tmr_d   = TMR_LOAD;
            end else begin
               retire = 1'b1;
            end
         end
         S_MEMORY: begin
            // mem_ready on the final allowed cycle still counts as success
            if (mem_ready) begin
               if (is_lw) state_d = S_WB;
               else       retire  = 1'b1;
            end else if (tmr_q == '0) begin
               mem_err_d = 1'b1;
               retire    = 1'b1;
            end else begin
               tmr_d = tmr_q - 1'b1;
            end
         end
         S_WB:   retire  = 1'b1;
         S_HALT: state_d = S_HALT;
         default: state_d = S_IDLE;
      endcase
      if (retire) begin
         if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
         state_d     = (run && !step_pend_q) ? S_FETCH : S_IDLE;
         step_pend_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         step_pend_q <= 1'b0;
         illegal_q   <= 1'b0;
         mem_err_q   <= 1'b0;
         cnt_q       <= '0;
         tmr_q       <= '0;
      end else begin
         state_q     <= state_d;
         step_pend_q <= step_pend_d;
         illegal_q   <= illegal_d;
         mem_err_q   <= mem_err_d;
         cnt_q       <= cnt_d;
         tmr_q       <= tmr_d;
      end
   end

   always_comb begin
      pc_we      = 1'b0;
      pc_src     = 1'b0;
      ir_we      = 1'b0;
      reg_we     = 1'b0;
      reg_dst    = 1'b0;
      alu_src    = 1'b0;
      alu_op     = 3'b000;
      mem_to_reg = 1'b0;
      mem_en_r   = 1'b0;
      mem_en_w   = 1'b0;
      halted     = 1'b0;
      case (state_q)
         S_FETCH: begin
            ir_we = 1'b1;
            pc_we = 1'b1;
         end
         S_EXECUTE: begin
            if (is_r) begin
               alu_op = 3'b010;
            end else if (is_addi || is_lw || is_sw) begin
               alu_src = 1'b1;
            end else if (is_beq) begin
               alu_op = 3'b001;
               pc_src = 1'b1;
               pc_we  = alu_zero;
            end
         end
         S_MEMORY: begin
            mem_en_r = is_lw;
            mem_en_w = is_sw;
         end
         S_WB: begin
            reg_we     = 1'b1;
            reg_dst    = is_r;
            mem_to_reg = is_lw;
         end
         S_HALT: halted = 1'b1;
         default: ;
      endcase
   end

   assign state       = state_q;
   assign illegal     = illegal_q;
   assign mem_err     = mem_err_q;
   assign instr_count = cnt_q;

endmodule

// File: tb/tb_secuenciador_multiciclo.sv
// Randomized bench for secuenciador_multiciclo: an instruction-level model expands each
// instruction into its expected per-cycle outputs and every cycle is compared against the DUT.
module tb_secuenciador_multiciclo;
   localparam int MT    = 15;
   localparam int CNT_W = 16;

   logic clk = 1'b0;
   logic rst_n, alu_zero, mem_ready, run, step;
   logic [5:0] opCode;
   logic pc_we, pc_src, ir_we, reg_we, reg_dst, alu_src, mem_to_reg, mem_en_r, mem_en_w;
   logic halted, illegal, mem_err;
   logic [2:0] alu_op, state;
   logic [CNT_W-1:0] instr_count;

   secuenciador_multiciclo #(.MEM_TIMEOUT(MT), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .opCode(opCode), .alu_zero(alu_zero), .mem_ready(mem_ready),
      .run(run), .step(step), .pc_we(pc_we), .pc_src(pc_src), .ir_we(ir_we), .reg_we(reg_we),
      .reg_dst(reg_dst), .alu_src(alu_src), .alu_op(alu_op), .mem_to_reg(mem_to_reg),
      .mem_en_r(mem_en_r), .mem_en_w(mem_en_w), .state(state), .halted(halted),
      .illegal(illegal), .mem_err(mem_err), .instr_count(instr_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0] st;
      logic pc_we, pc_src, ir_we, reg_we, reg_dst, alu_src;
      logic [2:0] alu_op;
      logic m2r, en_r, en_w, halted;
   } exp_t;

   int  tests = 0, errs = 0;
   int  m_cnt = 0;
   bit  m_ill = 0, m_err = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic exp_t blank(input logic [2:0] st);
      exp_t e;
      e = '{st: st, pc_we: 0, pc_src: 0, ir_we: 0, reg_we: 0, reg_dst: 0, alu_src: 0,
            alu_op: 3'b000, m2r: 0, en_r: 0, en_w: 0, halted: 0};
      return e;
   endfunction

   function automatic bit legal(input logic [5:0] op);
      return op == 6'b000000 || op == 6'b001000 || op == 6'b100011 ||
             op == 6'b101011 || op == 6'b000100;
   endfunction

   // Inputs are already driven for this cycle; compare, then move to the next negedge.
   task automatic tick(input exp_t e);
      #1;
      chk($sformatf("outs st%0d", e.st),
          {29'd0, state, pc_we, pc_src, ir_we, reg_we, reg_dst, alu_src, alu_op,
           mem_to_reg, mem_en_r, mem_en_w, halted},
          {29'd0, e.st, e.pc_we, e.pc_src, e.ir_we, e.reg_we, e.reg_dst, e.alu_src, e.alu_op,
           e.m2r, e.en_r, e.en_w, e.halted});
      chk("sticky/count", {14'd0, illegal, mem_err, instr_count},
          {14'd0, m_ill, m_err, m_cnt[CNT_W-1:0]});
      @(negedge clk);
   endtask

   task automatic noise();
      mem_ready = 1'($urandom_range(0, 1));
      alu_zero  = 1'($urandom_range(0, 1));
      step      = ($urandom_range(0, 3) == 0);
   endtask

   task automatic idle_cyc(input bit run_v, input bit step_v);
      noise();
      run  = run_v;
      step = step_v;
      tick(blank(3'd0));
   endtask

   // One instruction starting in FETCH; waits = cycles mem_ready stays low in MEMORY.
   task automatic do_instr(input logic [5:0] op, input bit az, input int waits,
                           input bit run_after, output int ncyc);
      exp_t e;
      bit is_r, is_addi, is_lw, is_sw, is_beq;
      is_r = (op == 6'b000000); is_addi = (op == 6'b001000); is_lw = (op == 6'b100011);
      is_sw = (op == 6'b101011); is_beq = (op == 6'b000100);
      ncyc = 0;
      opCode = op;
      run = run_after;
      noise();
      e = blank(3'd1); e.ir_we = 1; e.pc_we = 1;
      tick(e); ncyc++;
      noise();
      tick(blank(3'd2)); ncyc++;
      if (op == 6'b111111) return;
      if (!legal(op)) begin
         m_ill = 1; m_cnt++;
         return;
      end
      noise();
      e = blank(3'd3);
      if (is_r) e.alu_op = 3'b010;
      else if (is_beq) begin
         alu_zero = az;
         e.alu_op = 3'b001; e.pc_src = 1; e.pc_we = az;
      end else e.alu_src = 1;
      tick(e); ncyc++;
      if (is_beq) begin
         m_cnt++;
         return;
      end
      if (is_lw || is_sw) begin
         for (int i = 0; i <= waits && i < MT; i++) begin
            noise();
            mem_ready = (i == waits);
            e = blank(3'd4); e.en_r = is_lw; e.en_w = is_sw;
            tick(e); ncyc++;
         end
         if (waits >= MT) begin
            m_err = 1; m_cnt++;
            return;
         end
         if (is_sw) begin
            m_cnt++;
            return;
         end
      end
      noise();
      e = blank(3'd5); e.reg_we = 1; e.reg_dst = is_r; e.m2r = is_lw;
      tick(e); ncyc++;
      m_cnt++;
   endtask

   function automatic logic [5:0] rand_op();
      logic [5:0] t [5];
      logic [5:0] x;
      int r;
      t[0] = 6'b000000; t[1] = 6'b001000; t[2] = 6'b100011; t[3] = 6'b101011; t[4] = 6'b000100;
      r = $urandom_range(0, 7);
      if (r < 5) return t[r];
      x = 6'b010101;
      for (int k = 0; k < 100; k++) begin
         x = 6'($urandom_range(0, 63));
         if (!legal(x) && x != 6'b111111) break;
      end
      if (legal(x) || x == 6'b111111) x = 6'b010101;
      return x;
   endfunction

   task automatic do_reset();
      rst_n = 0; run = 0; step = 0;
      @(negedge clk); @(negedge clk);
      rst_n = 1;
      m_cnt = 0; m_ill = 0; m_err = 0;
   endtask

   initial begin
      int n, k;
      exp_t e;
      opCode = 6'b000000; alu_zero = 0; mem_ready = 0; run = 0; step = 0; rst_n = 0;
      @(negedge clk);
      do_reset();
      idle_cyc(0, 0);
      chk("reset count", 32'(instr_count), 32'd0);

      // Hand-computed sequence pinning the model
      idle_cyc(1, 0);
      do_instr(6'b000000, 0, 0, 1, n);  chk("rtype cycles", n, 4);
      chk("count after rtype", 32'(instr_count), 32'd1);
      do_instr(6'b000100, 1, 0, 1, n);  chk("beq taken cycles", n, 3);
      do_instr(6'b000100, 0, 0, 1, n);  chk("beq not-taken cycles", n, 3);
      do_instr(6'b100011, 0, 3, 1, n);  chk("lw 3 waits cycles", n, 8);
      do_instr(6'b101011, 0, 99, 1, n); chk("sw timeout cycles", n, 18);
      chk("mem_err after timeout", 32'(mem_err), 32'd1);
      do_instr(6'b001000, 0, 0, 1, n);  chk("addi cycles", n, 4);
      do_instr(6'b010101, 0, 0, 0, n);  chk("nop cycles", n, 2);
      idle_cyc(0, 0);
      chk("illegal sticky", 32'(illegal), 32'd1);
      chk("count after script", 32'(instr_count), 32'd7);

      // Single step with run raised mid-instruction: pending step still returns to IDLE
      idle_cyc(0, 1);
      do_instr(6'b000000, 0, 0, 1, n);
      idle_cyc(0, 0); idle_cyc(0, 0);
      chk("count after step", 32'(instr_count), 32'd8);

      for (int b = 0; b < 60; b++) begin
         case ($urandom_range(0, 2))
            0: begin
               k = $urandom_range(1, 4);
               idle_cyc(1, 0);
               for (int j = 0; j < k; j++)
                  do_instr(rand_op(), 1'($urandom_range(0, 1)), $urandom_range(0, MT + 2),
                           j < k - 1, n);
            end
            1: begin
               idle_cyc(0, 1);
               do_instr(rand_op(), 1'($urandom_range(0, 1)), $urandom_range(0, MT + 2),
                        1'($urandom_range(0, 1)), n);
            end
            default: idle_cyc(0, 0);
         endcase
      end

      // Synchronous reset in the middle of a MEMORY wait
      idle_cyc(1, 0);
      opCode = 6'b100011;
      noise(); e = blank(3'd1); e.ir_we = 1; e.pc_we = 1; tick(e);
      noise(); tick(blank(3'd2));
      noise(); e = blank(3'd3); e.alu_src = 1; tick(e);
      noise(); mem_ready = 0; e = blank(3'd4); e.en_r = 1; tick(e);
      noise(); mem_ready = 0; run = 0; step = 0; rst_n = 0; tick(e);
      rst_n = 1; m_cnt = 0; m_ill = 0; m_err = 0;
      idle_cyc(0, 0);
      chk("reset mid-memory count", 32'(instr_count), 32'd0);

      // HALT holds until reset, not counted
      idle_cyc(1, 0);
      do_instr(6'b000000, 0, 0, 1, n);
      do_instr(6'b111111, 0, 0, 1, n);
      chk("halt decode cycles", n, 2);
      for (int i = 0; i < 6; i++) begin
         noise(); run = 1'($urandom_range(0, 1));
         e = blank(3'd6); e.halted = 1; tick(e);
      end
      chk("halt count", 32'(instr_count), 32'd1);
      do_reset();
      idle_cyc(0, 0);

      $display("[TB] %0d tests run, %0d failed", tests, errs);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end
endmodule
